// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues imem requests and loads the IF/ID register {pc, inst}.
// Optional performance counters are enabled by defining INST_FETCH_PERF_CNT_EN.
module inst_fetch #(
    parameter int unsigned          PC_SIZE   = 32,
    parameter int unsigned          WORD_SIZE = 32,
    parameter logic [PC_SIZE-1:0]   RESET_PC  = PC_SIZE'(32'h0000_0000),
    parameter logic [WORD_SIZE-1:0] NOP_INST  = WORD_SIZE'(32'h0000_0013)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic [PC_SIZE-1:0]           i_branch_target,
    output logic                         o_imem_req,
    output logic [PC_SIZE-1:0]           o_imem_addr,
    input  logic [WORD_SIZE-1:0]         i_imem_rdata,
    input  logic                         i_imem_valid,
    output logic [PC_SIZE+WORD_SIZE-1:0] o_if_id_reg,
    output logic                         o_if_id_valid
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  o_fetch_cnt,
    output logic [31:0]                  o_bubble_cnt
`endif
);

    localparam int unsigned        IFID_W  = PC_SIZE + WORD_SIZE;
    localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(4);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

    state_t              state;
    logic [PC_SIZE-1:0]  pc_q;
    logic [PC_SIZE-1:0]  addr_q;
    logic                req_q;
    logic [IFID_W-1:0]   if_id_q;
    logic                if_id_valid_q;
    logic [IFID_W-1:0]   skid_q;

    logic [PC_SIZE-1:0]  flush_pc;
    logic [PC_SIZE-1:0]  pc_inc;
    logic                unused_target_lsbs;

    assign flush_pc           = {i_branch_target[PC_SIZE-1:2], 2'b00};
    assign pc_inc             = pc_q + PC_STEP;
    assign unused_target_lsbs = ^i_branch_target[1:0];

    // Fetch FSM; addr_q keeps the in-flight address so a redirect cannot disturb an open request
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state         <= IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            req_q         <= 1'b0;
            if_id_q       <= '0;
            if_id_valid_q <= 1'b0;
            skid_q        <= '0;
        end else if (i_flush) begin
            pc_q          <= flush_pc;
            if_id_q       <= {PC_SIZE'(0), NOP_INST};
            if_id_valid_q <= 1'b0;
            skid_q        <= '0;
            case (state)
                IDLE, HOLD: begin
                    state  <= WAIT;
                    req_q  <= 1'b1;
                    addr_q <= flush_pc;
                end
                WAIT, DROP: begin
                    if (i_imem_valid) begin
                        state  <= WAIT;
                        addr_q <= flush_pc;
                    end else begin
                        state  <= DROP;
                    end
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state  <= WAIT;
                    req_q  <= 1'b1;
                    addr_q <= pc_q;
                    if (!i_stall) if_id_valid_q <= 1'b0;
                end
                WAIT: begin
                    if (i_imem_valid) begin
                        if (!i_stall) begin
                            if_id_q       <= {pc_q, i_imem_rdata};
                            if_id_valid_q <= 1'b1;
                            pc_q          <= pc_inc;
                            addr_q        <= pc_inc;
                        end else begin
                            skid_q <= {pc_q, i_imem_rdata};
                            req_q  <= 1'b0;
                            state  <= HOLD;
                        end
                    end else if (!i_stall) begin
                        if_id_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        if_id_q       <= skid_q;
                        if_id_valid_q <= 1'b1;
                        pc_q          <= pc_inc;
                        addr_q        <= pc_inc;
                        req_q         <= 1'b1;
                        state         <= WAIT;
                    end
                end
                DROP: begin
                    if (!i_stall) if_id_valid_q <= 1'b0;
                    if (i_imem_valid) begin
                        state  <= WAIT;
                        addr_q <= pc_q;
                    end
                end
            endcase
        end
    end

    assign o_imem_req    = req_q;
    assign o_imem_addr   = addr_q;
    assign o_if_id_reg   = if_id_q;
    assign o_if_id_valid = if_id_valid_q;

`ifdef INST_FETCH_PERF_CNT_EN
    logic        load_c;
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    assign load_c = !i_flush && !i_stall && ((state == WAIT && i_imem_valid) || state == HOLD);

    // Fetches counted on real IF/ID loads, bubbles on unstalled cycles with an empty IF/ID
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (load_c) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (!i_stall && !if_id_valid_q) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign o_fetch_cnt  = fetch_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: transaction-level memory and scoreboard model plus directed literal checks.
module tb_inst_fetch;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] tgt = '0;
    logic        mvalid = 1'b0;
    logic [31:0] mrdata = '0;
    logic        req;
    logic [31:0] addr;
    logic [63:0] ifid;
    logic        ifv;

    logic        w_valid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [63:0] w_ifid;
    logic        w_ifv;

`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] fcnt, bcnt, w_fcnt, w_bcnt;
`endif

    inst_fetch dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
        .i_branch_target(tgt), .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_rdata(mrdata), .i_imem_valid(mvalid),
        .o_if_id_reg(ifid), .o_if_id_valid(ifv)
`ifdef INST_FETCH_PERF_CNT_EN
        , .o_fetch_cnt(fcnt), .o_bubble_cnt(bcnt)
`endif
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_stall(1'b0), .i_flush(1'b0),
        .i_branch_target(32'h0), .o_imem_req(w_req), .o_imem_addr(w_addr),
        .i_imem_rdata(w_rdata), .i_imem_valid(w_valid),
        .o_if_id_reg(w_ifid), .o_if_id_valid(w_ifv)
`ifdef INST_FETCH_PERF_CNT_EN
        , .o_fetch_cnt(w_fcnt), .o_bubble_cnt(w_bcnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: scoreboard of accepted-but-not-decoded words, expected IF/ID and next fetch address
    logic [63:0] exp_ifid = '0;
    logic        exp_ifv  = 1'b0;
    logic [31:0] exp_next = RST_PC;
    logic [63:0] pendq[$];
    bit          squashed = 0;
    bit          started  = 0;

    bit          outst = 0;
    int          cnt   = 0;
    int          lat   = 1;
    logic [31:0] maddr = '0;
    logic [31:0] last_cap = '0;
    bit          cap_now = 0, del_now = 0;

    logic        prev_rst = 1'b0, prev_req = 1'b0, prev_mvalid = 1'b0;
    logic [31:0] prev_addr = '0;

    bit          w_outst = 0;
    logic [31:0] w_maddr = '0;
    logic [31:0] w_caps[$];
    bit          w_got = 0;
    logic [63:0] w_first = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_8113;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: check outputs of the last edge, drive this cycle's inputs, advance the model
    task automatic tick(input logic r, input logic s, input logic f, input logic [31:0] t);
        @(negedge clk);
        if (started) begin
            chk("if_id_valid", 64'(ifv), 64'(exp_ifv));
            chk("if_id_reg", ifid, exp_ifid);
            if (!prev_rst) begin
                chk("req_after_reset", 64'(req), 64'd0);
            end else if (prev_req && !prev_mvalid) begin
                chk("req_held", 64'(req), 64'd1);
                chk("addr_held", 64'(addr), 64'(prev_addr));
            end
            if (pendq.size() != 0) chk("req_while_holding", 64'(req), 64'd0);
        end
        if (!w_got && started && w_ifv === 1'b1) begin
            w_got   = 1;
            w_first = w_ifid;
        end

        rst = r; stall = s; flush = f; tgt = t;
        cap_now = 0; del_now = 0;
        mvalid = 1'b0; mrdata = 32'hDEAD_BEEF;
        if (!r) begin
            outst = 0;
        end else if (outst) begin
            if (cnt <= 1) begin
                mvalid  = 1'b1;
                mrdata  = mem_word(maddr);
                del_now = 1;
                outst   = 0;
            end else begin
                cnt--;
            end
        end else if (started && req === 1'b1) begin
            outst    = 1;
            cnt      = lat;
            maddr    = addr;
            last_cap = addr;
            cap_now  = 1;
            chk("fetch_addr", 64'(addr), 64'(exp_next));
        end

        w_valid = 1'b0;
        if (!r) begin
            w_outst = 0;
        end else if (w_outst) begin
            w_valid = 1'b1;
            w_rdata = mem_word(w_maddr);
            w_outst = 0;
        end else if (w_req === 1'b1) begin
            w_outst = 1;
            w_maddr = w_addr;
            w_caps.push_back(w_addr);
        end

        if (!r) begin
            exp_ifid = '0; exp_ifv = 1'b0; exp_next = RST_PC;
            pendq.delete(); squashed = 0;
        end else if (f) begin
            exp_ifid = {32'h0, NOP}; exp_ifv = 1'b0;
            exp_next = t & ~32'h3;
            pendq.delete();
            squashed = outst;
        end else begin
            if (del_now) begin
                if (squashed) squashed = 0;
                else begin
                    pendq.push_back({maddr, mrdata});
                    exp_next = maddr + 32'd4;
                end
            end
            if (!s) begin
                if (pendq.size() != 0) begin
                    exp_ifid = pendq.pop_front();
                    exp_ifv  = 1'b1;
                end else begin
                    exp_ifv = 1'b0;
                end
            end
        end
        prev_rst = r; prev_req = req; prev_addr = addr; prev_mvalid = mvalid;
        started = 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_cap(input string name, input logic [31:0] a);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            found = cap_now;
        end
        chk({name, "_seen"}, 64'(found), 64'd1);
        chk(name, 64'(last_cap), 64'(a));
    endtask

    task automatic wait_due();
        for (int i = 0; i < 20 && !(outst && cnt <= 1); i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("response_due", 64'(outst && cnt <= 1), 64'd1);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_req"}, 64'(req), 64'd0);
        chk({name, "_ifid"}, ifid, 64'd0);
        chk({name, "_valid"}, 64'(ifv), 64'd0);
`ifdef INST_FETCH_PERF_CNT_EN
        chk({name, "_fetch_cnt"}, 64'(fcnt), 64'd0);
        chk({name, "_bubble_cnt"}, 64'(bcnt), 64'd0);
`endif
    endtask

    initial begin
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        chk_reset_state("reset");

        // Two back-to-back fetches with 1-cycle memory
        wait_cap("first_addr", 32'h0);
        run(2);
        chk("ifid_0", ifid, 64'h0000_0000_0050_0093);
        chk("valid_0", 64'(ifv), 64'd1);
        chk("second_cap", 64'(cap_now), 64'd1);
        chk("second_addr", 64'(last_cap), 64'h4);
        run(2);
        chk("ifid_4", ifid, 64'h0000_0004_0010_8113);
        chk("valid_4", 64'(ifv), 64'd1);
        chk("third_addr", 64'(last_cap), 64'h8);

        // Stall while the 0x8 response lands
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold_req", 64'(req), 64'd0);
        chk("hold_ifid", ifid, 64'h0000_0004_0010_8113);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        run(2);
        chk("ifid_8", ifid, 64'h0000_0008_5A5A_001B);
        chk("valid_8", 64'(ifv), 64'd1);
        chk("addr_c", 64'(last_cap), 64'hC);

        // Redirect while the 0x10 request is outstanding
        lat = 3;
        wait_cap("addr_10", 32'h10);
        tick(1'b1, 1'b0, 1'b1, 32'h0000_0102);
        run(1);
        chk("flush_ifid", ifid, {32'h0, NOP});
        chk("flush_valid", 64'(ifv), 64'd0);
        chk("drop_addr", 64'(addr), 64'h10);
        run(2);
        chk("redirect_cap", 64'(cap_now), 64'd1);
        chk("redirect_addr", 64'(last_cap), 64'h100);

        // Flush, stall and response together: flush wins
        wait_due();
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        run(1);
        chk("fsv_ifid", ifid, {32'h0, NOP});
        chk("fsv_valid", 64'(ifv), 64'd0);
        chk("fsv_req", 64'(req), 64'd1);
        chk("fsv_addr", 64'(last_cap), 64'h200);

        // Redirect to the top of the address space, ignoring target LSBs
        lat = 1;
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        wait_cap("top_addr", 32'hFFFF_FFFC);
        run(2);
        chk("wrap_addr", 64'(last_cap), 64'h0);

        // Reset with a request outstanding
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        run(1);
        chk_reset_state("reset_wait");
        wait_cap("rst_pc_wait", RST_PC);

        // Reset while holding a stalled response
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("pre_rst_hold_req", 64'(req), 64'd0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        run(1);
        chk_reset_state("reset_hold");
        wait_cap("rst_pc_hold", RST_PC);
        run(8);

        // Instance reset to 0xFFFF_FFFC
        chk("wrap_inst_caps", 64'(w_caps.size() >= 2), 64'd1);
        if (w_caps.size() >= 2) begin
            chk("wrap_inst_addr0", 64'(w_caps[0]), 64'hFFFF_FFFC);
            chk("wrap_inst_addr1", 64'(w_caps[1]), 64'h0);
        end
        chk("wrap_inst_ifid", w_first, 64'hFFFF_FFFC_A5A5_FFEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
